// File: rtl/ascon_seq_pkg.sv
// Shared types and constants for the Ascon AEAD host sequencer.
// Optional feature macro: ASCON_SEQ_LFSR_EN (internal mask LFSR).
package ascon_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DELAY,
        S_READ,
        S_DONE
    } seq_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0 .. v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Bit-field offsets of the 22-bit mask word:
    // {r128[2:0], rpt[2:0], key[4:1], ad[4:1], pt[4:1], nonce[4:1]}
    localparam int MSK_NONCE = 0;
    localparam int MSK_PT    = 4;
    localparam int MSK_AD    = 8;
    localparam int MSK_KEY   = 12;
    localparam int MSK_RPT   = 16;
    localparam int MSK_R128  = 19;
    localparam int MSK_W     = 22;

    // Galois LFSR, x^32+x^22+x^2+x+1, right-shifting form.
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/ascon_mask_lfsr.sv
// 32-bit Galois LFSR producing mask randomness for the sequencer.
// Only instantiated when ASCON_SEQ_LFSR_EN is defined.
module ascon_mask_lfsr
    import ascon_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q, lfsr_d;

    // Step once per enabled cycle; hold otherwise.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    end

    // State register, reseeded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ascon_aead_sequencer.sv
// Host-side sequencer for the serial masked Ascon AEAD core: latches a
// parallel command, shifts operands in MSB first with mask bits, pulses
// the selected start line, waits for ready (with timeout), then shifts
// results back LSB first into parallel registers.
// Optional feature macro: ASCON_SEQ_LFSR_EN -- masks from internal LFSR
// instead of rndxSI.
module ascon_aead_sequencer
    import ascon_seq_pkg::*;
#(
    parameter int K            = 128,
    parameter int L            = 64,
    parameter int Y            = 64,
    parameter int START_CYCLES = 5,
    parameter int READ_DELAY   = 4,
    parameter int TIMEOUT      = 4095
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_validxSI,
    output logic           cmd_readyxSO,
    input  logic           cmd_decxSI,
    input  logic [K-1:0]   keyxSI,
    input  logic [127:0]   noncexSI,
    input  logic [L-1:0]   adxSI,
    input  logic [Y-1:0]   dinxSI,
    input  logic [21:0]    rndxSI,
    output logic [4:0]     core_keyxSO,
    output logic [4:0]     core_noncexSO,
    output logic [4:0]     core_adxSO,
    output logic [4:0]     core_ptxSO,
    output logic [2:0]     core_r128xSO,
    output logic [2:0]     core_rptxSO,
    output logic           core_enc_startxSO,
    output logic           core_dec_startxSO,
    input  logic           core_enc_readyxSI,
    input  logic           core_dec_readyxSI,
    input  logic           core_ctxSI,
    input  logic           core_ptxSI,
    input  logic           core_tagxSI,
    input  logic           core_dtagxSI,
    input  logic           core_authxSI,
    output logic           res_validxSO,
    input  logic           res_readyxSI,
    output logic [Y-1:0]   doutxSO,
    output logic [127:0]   tagxSO,
    output logic           authxSO,
    output logic           timeoutxSO
);

    localparam int LOAD_LEN = max2(max2(K, L), max2(Y, 128));
    localparam int OUT_LEN  = max2(Y, 128);
    localparam int CW       = clog2(max2(max2(LOAD_LEN, OUT_LEN), TIMEOUT + 1));

    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Operands are held in shift registers; the MSB is the bit on the wire,
    // and zeros shifted in cover indices past a field's width.
    logic [K-1:0]    key_sr_q, key_sr_d;
    logic [127:0]    non_sr_q, non_sr_d;
    logic [L-1:0]    ad_sr_q,  ad_sr_d;
    logic [Y-1:0]    din_sr_q, din_sr_d;
    logic            dec_q,    dec_d;

    logic [Y-1:0]    dout_q,   dout_d;
    logic [127:0]    tag_q,    tag_d;
    logic            auth_q,   auth_d;
    logic            to_q,     to_d;

    logic            rdy_sel;
    logic            dout_bit;
    logic            tag_bit;
    logic            load_act;
    logic            mask_en;
    logic [MSK_W-1:0] msk;

    assign rdy_sel  = dec_q ? core_dec_readyxSI : core_enc_readyxSI;
    assign dout_bit = dec_q ? core_ptxSI   : core_ctxSI;
    assign tag_bit  = dec_q ? core_dtagxSI : core_tagxSI;

`ifdef ASCON_SEQ_LFSR_EN
    logic [31:0] lfsr;
    logic        unused_rnd;

    ascon_mask_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != S_IDLE),
        .lfsr_o (lfsr)
    );

    assign msk        = lfsr[MSK_W-1:0];
    assign unused_rnd = ^rndxSI;
`else
    assign msk = rndxSI;
`endif

    // Next-state, counter and datapath updates for the command sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_sr_d = key_sr_q;
        non_sr_d = non_sr_q;
        ad_sr_d  = ad_sr_q;
        din_sr_d = din_sr_q;
        dec_d    = dec_q;
        dout_d   = dout_q;
        tag_d    = tag_q;
        auth_d   = auth_q;
        to_d     = to_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_validxSI) begin
                    key_sr_d = keyxSI;
                    non_sr_d = noncexSI;
                    ad_sr_d  = adxSI;
                    din_sr_d = dinxSI;
                    dec_d    = cmd_decxSI;
                    dout_d   = '0;
                    tag_d    = '0;
                    auth_d   = 1'b0;
                    to_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                key_sr_d = {key_sr_q[K-2:0], 1'b0};
                non_sr_d = {non_sr_q[126:0], 1'b0};
                ad_sr_d  = {ad_sr_q[L-2:0],  1'b0};
                din_sr_d = {din_sr_q[Y-2:0], 1'b0};
                if (int'(cnt_q) == LOAD_LEN - 1) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_START: begin
                if (int'(cnt_q) == START_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                // Ready wins over a timeout expiring in the same cycle.
                if (rdy_sel) begin
                    cnt_d   = '0;
                    state_d = S_DELAY;
                end else if (int'(cnt_q) == TIMEOUT - 1) begin
                    to_d    = 1'b1;
                    dout_d  = '0;
                    tag_d   = '0;
                    auth_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DELAY: begin
                if (int'(cnt_q) == READ_DELAY - 1) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_READ: begin
                // Shift in from the top so bit i lands at index i once full.
                if (int'(cnt_q) < Y)   dout_d = {dout_bit, dout_q[Y-1:1]};
                if (int'(cnt_q) < 128) tag_d  = {tag_bit, tag_q[127:1]};
                if (int'(cnt_q) == OUT_LEN - 1) begin
                    auth_d  = dec_q & core_authxSI;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (res_readyxSI) begin
                    to_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and shared cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand shift registers and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sr_q <= '0;
            non_sr_q <= '0;
            ad_sr_q  <= '0;
            din_sr_q <= '0;
            dec_q    <= 1'b0;
            dout_q   <= '0;
            tag_q    <= '0;
            auth_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            key_sr_q <= key_sr_d;
            non_sr_q <= non_sr_d;
            ad_sr_q  <= ad_sr_d;
            din_sr_q <= din_sr_d;
            dec_q    <= dec_d;
            dout_q   <= dout_d;
            tag_q    <= tag_d;
            auth_q   <= auth_d;
            to_q     <= to_d;
        end
    end

    // Core-side outputs decode straight from state so reset drops them at once.
    assign load_act = (state_q == S_LOAD);
    assign mask_en  = (state_q == S_LOAD)  || (state_q == S_START) ||
                      (state_q == S_WAIT)  || (state_q == S_DELAY) ||
                      (state_q == S_READ);

    assign core_keyxSO   = {mask_en ? msk[MSK_KEY   +: 4] : 4'b0, load_act & key_sr_q[K-1]};
    assign core_noncexSO = {mask_en ? msk[MSK_NONCE +: 4] : 4'b0, load_act & non_sr_q[127]};
    assign core_adxSO    = {mask_en ? msk[MSK_AD    +: 4] : 4'b0, load_act & ad_sr_q[L-1]};
    assign core_ptxSO    = {mask_en ? msk[MSK_PT    +: 4] : 4'b0, load_act & din_sr_q[Y-1]};
    assign core_r128xSO  = mask_en ? msk[MSK_R128 +: 3] : 3'b0;
    assign core_rptxSO   = mask_en ? msk[MSK_RPT  +: 3] : 3'b0;

    assign core_enc_startxSO = (state_q == S_START) & ~dec_q;
    assign core_dec_startxSO = (state_q == S_START) &  dec_q;

    assign cmd_readyxSO = (state_q == S_IDLE);
    assign res_validxSO = (state_q == S_DONE);
    assign doutxSO      = dout_q;
    assign tagxSO       = tag_q;
    assign authxSO      = auth_q;
    assign timeoutxSO   = to_q;

endmodule
